oam_dma_bus: RTL and testbench

Bus front-end between the sm83 core's memory port (addr/d_out/write) and the system: routes CPU accesses to the external bus, OAM or internal HRAM, and runs the OAM DMA engine triggered by writes to FF46. During DMA it owns the external bus and OAM, and isolates the CPU to HRAM and FF46.

---
 rtl/oam_dma_bus_if.sv | 33 +++
 rtl/oam_dma_bus.sv | 110 +++++++++++
 tb/tb_oam_dma_bus.sv | 312 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/oam_dma_bus_if.sv
// Signal bundle between the sm83 memory port, the external bus and OAM.
// slave is the bus front-end, master is whatever drives the CPU side.
interface oam_dma_bus_if;
    logic [15:0] cpu_addr;
    logic [7:0]  cpu_wdata;
    logic        cpu_write;
    logic [7:0]  cpu_rdata;
    logic [15:0] bus_addr;
    logic [7:0]  bus_wdata;
    logic        bus_write;
    logic [7:0]  bus_rdata;
    logic [7:0]  oam_addr;
    logic [7:0]  oam_wdata;
    logic        oam_we;
    logic [7:0]  oam_rdata;
    logic        dma_active;

    modport slave (
        input  cpu_addr, cpu_wdata, cpu_write,
        input  bus_rdata, oam_rdata,
        output cpu_rdata, bus_addr, bus_wdata,
        output bus_write, oam_addr, oam_wdata,
        output oam_we, dma_active
    );

    modport master (
        output cpu_addr, cpu_wdata, cpu_write,
        output bus_rdata, oam_rdata,
        input  cpu_rdata, bus_addr, bus_wdata,
        input  bus_write, oam_addr, oam_wdata,
        input  oam_we, dma_active
    );
endinterface

// File: rtl/oam_dma_bus.sv
// sm83 memory front-end: address decode, HRAM, and the FF46 OAM DMA engine.
// During DMA the engine owns bus and OAM; the CPU only sees HRAM and FF46.
module oam_dma_bus (
    input logic          clk,
    input logic          rst,
    oam_dma_bus_if.slave b
);
    typedef enum logic [1:0] {
        IDLE,
        START,
        XFER
    } state_t;

    state_t     state;
    logic [7:0] src_hi;
    logic [7:0] idx;
    logic       dma_act;
    logic [7:0] hram [127];

    logic       is_fe;
    logic       is_oam;
    logic       is_reg;
    logic       is_hram;
    logic       is_ext;
    logic       xfer;
    logic       reg_wr;
    logic [7:0] src_eff;

    assign is_fe   = b.cpu_addr[15:8] == 8'hFE;
    assign is_oam  = is_fe && (b.cpu_addr[7:0] < 8'hA0);
    assign is_reg  = b.cpu_addr == 16'hFF46;
    assign is_hram = (b.cpu_addr >= 16'hFF80) &&
                     (b.cpu_addr != 16'hFFFF);
    assign is_ext  = !is_fe && !is_reg && !is_hram;
    assign xfer    = state == XFER;
    assign reg_wr  = b.cpu_write && is_reg;

    // Echo RAM sources E0..FF fold back onto C0..DF
    assign src_eff = (src_hi < 8'hE0) ? src_hi
                                      : src_hi - 8'h20;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state   <= IDLE;
            idx     <= 8'h00;
            src_hi  <= 8'h00;
            dma_act <= 1'b0;
        end else if (reg_wr) begin
            state   <= START;
            idx     <= 8'h00;
            src_hi  <= b.cpu_wdata;
            dma_act <= 1'b1;
        end else begin
            unique case (state)
                START: state <= XFER;
                XFER: begin
                    idx <= idx + 8'h01;
                    if (idx == 8'h9F) begin
                        state   <= IDLE;
                        dma_act <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst && b.cpu_write && is_hram)
            hram[b.cpu_addr[6:0]] <= b.cpu_wdata;
    end

    always_comb begin
        b.cpu_rdata = b.bus_rdata;
        if (!rst)
            b.cpu_rdata = 8'hFF;
        else if (is_reg)
            b.cpu_rdata = src_hi;
        else if (is_hram)
            b.cpu_rdata = hram[b.cpu_addr[6:0]];
        else if (dma_act)
            b.cpu_rdata = 8'hFF;
        else if (is_oam)
            b.cpu_rdata = b.oam_rdata;
        else if (is_fe)
            b.cpu_rdata = 8'h00;
    end

    always_comb begin
        b.bus_addr  = b.cpu_addr;
        b.bus_wdata = b.cpu_wdata;
        b.bus_write = b.cpu_write && is_ext;
        b.oam_addr  = b.cpu_addr[7:0];
        b.oam_wdata = b.cpu_wdata;
        b.oam_we    = b.cpu_write && is_oam;
        if (!rst) begin
            b.bus_addr  = 16'h0000;
            b.bus_write = 1'b0;
            b.oam_we    = 1'b0;
        end else if (dma_act) begin
            b.bus_addr  = {src_eff, idx};
            b.bus_write = 1'b0;
            b.oam_addr  = idx;
            b.oam_wdata = b.bus_rdata;
            b.oam_we    = xfer;
        end
    end

    assign b.dma_active = dma_act;
endmodule

// File: tb/tb_oam_dma_bus.sv
// Bench for oam_dma_bus: routing table, random CPU traffic against a
// memory-map model, and DMA sequences (full, echo, restart, reset).
module tb_oam_dma_bus;
    logic clk = 1'b0;
    logic rst = 1'b0;
    oam_dma_bus_if b ();

    oam_dma_bus dut (.clk(clk), .rst(rst), .b(b));

    always #5 clk = ~clk;

    logic [7:0]  ext_m [65536];
    logic [7:0]  oam_m [160];
    logic [7:0]  hram_m [127];
    bit          hram_v [127];
    logic [7:0]  ff46_m;
    logic [7:0]  oam_log [$];
    logic [15:0] addr_log [$];
    int tests = 0;
    int fails = 0;

    assign b.bus_rdata = ext_m[b.bus_addr];
    assign b.oam_rdata = (b.oam_addr < 8'd160) ?
                         oam_m[b.oam_addr] : 8'h00;

    always @(posedge clk) begin
        if (b.oam_we) begin
            oam_log.push_back(b.oam_addr);
            addr_log.push_back(b.bus_addr);
            if (b.oam_addr < 8'd160)
                oam_m[b.oam_addr] <= b.oam_wdata;
        end
        if (b.bus_write)
            ext_m[b.bus_addr] <= b.bus_wdata;
    end

    typedef struct {
        logic [15:0] addr;
        logic [7:0]  wdata;
        logic        wr;
        logic        bw;
        logic        we;
        logic [7:0]  rd;
        logic        crd;
    } vec_t;

    task automatic chk(input string nm, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] eff(input logic [7:0] s);
        return (s >= 8'd224) ? s - 8'd32 : s;
    endfunction

    task automatic drive(input logic [15:0] a, input logic [7:0] d,
                         input logic w);
        b.cpu_addr  = a;
        b.cpu_wdata = d;
        b.cpu_write = w;
    endtask

    task automatic wait_log(input int k);
        int n = 0;
        while (oam_log.size() < k && n < 300) begin
            tick();
            n++;
        end
        chk("wait_log_timeout", int'(n < 300), 1);
    endtask

    task automatic dma_finish(input logic [7:0] src,
                              input logic [15:0] base);
        int n = 0;
        int errs = 0;
        oam_log.delete();
        addr_log.delete();
        drive(16'h0000, 8'h00, 1'b0);
        #1;
        chk("start_active", b.dma_active, 1);
        chk("start_no_oam_we", b.oam_we, 0);
        // START plus 160 transfer cycles
        while (b.dma_active && n < 400) begin
            n++;
            tick();
        end
        chk("dma_active_len", n, 161);
        chk("oam_write_count", oam_log.size(), 160);
        for (int i = 0; i < 160; i++) begin
            if (i < oam_log.size()) begin
                if (oam_log[i] != 8'(i)) errs++;
                if (addr_log[i] != base + 16'(i)) errs++;
            end
            if (oam_m[i] != ext_m[base + 16'(i)]) errs++;
        end
        chk("dma_seq_errors", errs, 0);
        ff46_m = src;
        drive(16'hFF46, 8'h00, 1'b0);
        #1;
        chk("ff46_read", b.cpu_rdata, src);
    endtask

    task automatic kick(input logic [7:0] src);
        oam_log.delete();
        addr_log.delete();
        drive(16'hFF46, src, 1'b1);
        tick();
        drive(16'h0000, 8'h00, 1'b0);
    endtask

    vec_t vt [10];

    initial begin
        logic [15:0] a;
        logic [7:0]  d, s, old;
        logic        w;
        logic [7:0]  erd;
        logic        ebw, ewe, crd;
        int          r, k, n;

        for (int i = 0; i < 65536; i++) ext_m[i] = 8'($urandom);
        for (int i = 0; i < 160; i++) oam_m[i] = 8'h00;
        for (int i = 0; i < 127; i++) hram_v[i] = 1'b0;
        ff46_m = 8'h00;

        drive(16'hC000, 8'h11, 1'b1);
        #1;
        chk("rst_bus_write", b.bus_write, 0);
        chk("rst_bus_addr", b.bus_addr, 0);
        chk("rst_rdata", b.cpu_rdata, 8'hFF);
        tick();
        tick();
        rst = 1'b1;
        drive(16'h0000, 8'h00, 1'b0);
        #1;
        chk("rst_dma_active", b.dma_active, 0);

        vt[0] = '{16'hC123, 8'h5A, 1, 1, 0, 8'h00, 0};
        vt[1] = '{16'hFE10, 8'h77, 1, 0, 1, 8'h00, 0};
        vt[2] = '{16'hFE10, 8'h00, 0, 0, 0, 8'h77, 1};
        vt[3] = '{16'hFEA5, 8'h00, 0, 0, 0, 8'h00, 1};
        vt[4] = '{16'hFEA5, 8'h99, 1, 0, 0, 8'h00, 1};
        vt[5] = '{16'hFF90, 8'h33, 1, 0, 0, 8'h00, 0};
        vt[6] = '{16'hFF90, 8'h00, 0, 0, 0, 8'h33, 1};
        vt[7] = '{16'hFF46, 8'h00, 0, 0, 0, 8'h00, 1};
        vt[8] = '{16'hC123, 8'h00, 0, 0, 0, 8'h5A, 1};
        vt[9] = '{16'hFFFF, 8'h01, 1, 1, 0, 8'h00, 0};
        for (int i = 0; i < 10; i++) begin
            drive(vt[i].addr, vt[i].wdata, vt[i].wr);
            #1;
            chk($sformatf("vec%0d_bus_write", i),
                b.bus_write, vt[i].bw);
            chk($sformatf("vec%0d_oam_we", i), b.oam_we, vt[i].we);
            if (vt[i].bw)
                chk($sformatf("vec%0d_bus_addr", i),
                    b.bus_addr, vt[i].addr);
            if (vt[i].we)
                chk($sformatf("vec%0d_oam_addr", i),
                    b.oam_addr, vt[i].addr[7:0]);
            if (vt[i].crd)
                chk($sformatf("vec%0d_rdata", i),
                    b.cpu_rdata, vt[i].rd);
            tick();
        end
        hram_m[16] = 8'h33;
        hram_v[16] = 1'b1;

        for (int it = 0; it < 300; it++) begin
            r = $urandom_range(0, 4);
            w = 1'($urandom);
            d = 8'($urandom);
            unique case (r)
                0: a = 16'($urandom_range(0, 16'hFDFF));
                1: a = 16'hFE00 + 16'($urandom_range(0, 8'h9F));
                2: a = 16'hFEA0 + 16'($urandom_range(0, 8'h5F));
                3: a = 16'hFF80 + 16'($urandom_range(0, 8'h7E));
                default: begin
                    a = 16'hFF00 + 16'($urandom_range(0, 8'h7F));
                    if (a == 16'hFF46) w = 1'b0;
                end
            endcase
            ebw = 1'b0;
            ewe = 1'b0;
            crd = 1'b1;
            if (a == 16'hFF46) begin
                erd = ff46_m;
            end else if (a >= 16'hFF80 && a <= 16'hFFFE) begin
                erd = hram_m[a - 16'hFF80];
                crd = hram_v[a - 16'hFF80];
            end else if (a >= 16'hFE00 && a < 16'hFEA0) begin
                erd = oam_m[a - 16'hFE00];
                ewe = w;
            end else if (a >= 16'hFEA0 && a <= 16'hFEFF) begin
                erd = 8'h00;
            end else begin
                erd = ext_m[a];
                ebw = w;
            end
            drive(a, d, w);
            #1;
            chk("rand_bus_write", b.bus_write, ebw);
            chk("rand_oam_we", b.oam_we, ewe);
            if (ebw) chk("rand_bus_addr", b.bus_addr, a);
            if (ewe) chk("rand_oam_addr", b.oam_addr, a[7:0]);
            if (crd) chk("rand_rdata", b.cpu_rdata, erd);
            if (w && a >= 16'hFF80 && a <= 16'hFFFE) begin
                hram_m[a - 16'hFF80] = d;
                hram_v[a - 16'hFF80] = 1'b1;
            end
            tick();
        end
        drive(16'h0000, 8'h00, 1'b0);

        for (int i = 0; i < 160; i++)
            ext_m[16'hC000 + 16'(i)] = 8'(i) ^ 8'hA5;
        kick(8'hC0);
        dma_finish(8'hC0, 16'hC000);
        k = 0;
        for (int i = 0; i < 160; i++)
            if (oam_m[i] != (8'(i) ^ 8'hA5)) k++;
        chk("full_dma_pattern", k, 0);

        kick(8'hFE);
        dma_finish(8'hFE, 16'hDE00);

        for (int j = 0; j < 3; j++) begin
            s = 8'($urandom);
            kick(s);
            dma_finish(s, {eff(s), 8'h00});
        end

        kick(8'hC0);
        wait_log(5);
        drive(16'h8000, 8'h00, 1'b0);
        #1;
        chk("iso_read_ff", b.cpu_rdata, 8'hFF);
        old = ext_m[16'hD000];
        drive(16'hD000, 8'h12, 1'b1);
        #1;
        chk("iso_bus_write", b.bus_write, 0);
        chk("iso_oam_addr", b.oam_addr, 5);
        chk("iso_oam_wdata", b.oam_wdata, ext_m[16'hC005]);
        tick();
        chk("iso_ext_kept", ext_m[16'hD000], old);
        drive(16'hFFFE, 8'h3C, 1'b1);
        tick();
        drive(16'hFFFE, 8'h00, 1'b0);
        #1;
        chk("iso_hram", b.cpu_rdata, 8'h3C);
        hram_m[126] = 8'h3C;
        hram_v[126] = 1'b1;
        drive(16'h0000, 8'h00, 1'b0);
        n = 0;
        while (b.dma_active && n < 400) begin
            tick();
            n++;
        end
        chk("iso_dma_count", oam_log.size(), 160);

        for (int i = 0; i < 160; i++)
            ext_m[16'hD100 + 16'(i)] = 8'($urandom);
        kick(8'hC0);
        wait_log(50);
        drive(16'hFF46, 8'hD1, 1'b1);
        #1;
        chk("restart_inflight_we", b.oam_we, 1);
        chk("restart_inflight_idx", b.oam_addr, 50);
        tick();
        chk("restart_inflight_log", oam_log.size(), 51);
        dma_finish(8'hD1, 16'hD100);

        kick(8'hC0);
        wait_log(80);
        rst = 1'b0;
        #1;
        chk("rstx_oam_we", b.oam_we, 0);
        chk("rstx_bus_addr", b.bus_addr, 0);
        chk("rstx_rdata", b.cpu_rdata, 8'hFF);
        tick();
        rst = 1'b1;
        #1;
        chk("rstx_dma_active", b.dma_active, 0);
        for (int i = 0; i < 170; i++) tick();
        chk("rstx_no_more_we", oam_log.size(), 80);
        drive(16'hFF46, 8'h00, 1'b0);
        #1;
        chk("rstx_ff46", b.cpu_rdata, 8'h00);
        drive(16'hC000, 8'h42, 1'b1);
        #1;
        chk("rstx_bus_write", b.bus_write, 1);
        chk("rstx_bus_addr_c000", b.bus_addr, 16'hC000);
        tick();
        drive(16'h0000, 8'h00, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got 1 expected 0");
        $fatal(1, "timeout");
    end
endmodule
